// File: rtl/ll_rd_pkg.sv
// Shared types for the linked-list read walker.
package ll_rd_pkg;

    // Command opcodes: SINGLE=0, TRAVERSE=1, TRAV_DATA=2, TRAV_HIST=3.
    typedef enum logic [1:0] {
        OpSingle   = 2'd0,
        OpTraverse = 2'd1,
        OpTravData = 2'd2,
        OpTravHist = 2'd3
    } t_ll_rd_op;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StFetch,
        StFwait,
        StResp
    } t_ll_rd_walk_state;

endpackage

// File: rtl/ll_ptr_hist_shreg.sv
// Shift register of the most recently visited pointers; slice 0 holds the newest entry.
module ll_ptr_hist_shreg #(
    parameter int unsigned PTR_W      = 8,
    parameter int unsigned HIST_DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        en,
    input  logic [PTR_W-1:0]            din,
    output logic [HIST_DEPTH*PTR_W-1:0] hist
);

    logic [HIST_DEPTH*PTR_W-1:0] hist_q;
    logic [HIST_DEPTH*PTR_W-1:0] hist_shifted;

    generate
        if (HIST_DEPTH == 1) begin : g_one
            assign hist_shifted = din;
        end else begin : g_many
            assign hist_shifted = {hist_q[(HIST_DEPTH-1)*PTR_W-1:0], din};
        end
    endgenerate

    // Clear wins over shift so a new command always starts from an all-zero window.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            hist_q <= '0;
        end else if (en) begin
            hist_q <= hist_shifted;
        end
    end

    assign hist = hist_q;

endmodule

// File: rtl/ll_rd_walker_v3.sv
// Linked-list read engine: walks nxtptrMem from a start pointer for a hop count and
// optionally returns the final node's data/link and a history of visited pointers.
module ll_rd_walker_v3
    import ll_rd_pkg::*;
#(
    parameter int unsigned      PTR_W      = 8,
    parameter int unsigned      DATA_W     = 32,
    parameter int unsigned      CNT_W      = 8,
    parameter int unsigned      HIST_DEPTH = 3,
    parameter logic [PTR_W-1:0] NULL_PTR   = '1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_vld,
    output logic                        cmd_rdy,
    input  logic [1:0]                  cmd_op,
    input  logic [PTR_W-1:0]            cmd_ptr,
    input  logic [CNT_W-1:0]            cmd_hops,
    output logic                        rsp_vld,
    input  logic                        rsp_rdy,
    output logic [PTR_W-1:0]            rsp_ptr,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [PTR_W-1:0]            rsp_link,
    output logic [HIST_DEPTH*PTR_W-1:0] rsp_hist,
    output logic                        rsp_err,
    output logic                        nxt_rd_vld,
    output logic [PTR_W-1:0]            nxt_rd_addr,
    input  logic [PTR_W-1:0]            nxt_rd_data,
    input  logic                        nxt_rd_dvld,
    output logic                        dat_rd_vld,
    output logic [PTR_W-1:0]            dat_rd_addr,
    input  logic [DATA_W-1:0]           dat_rd_data,
    input  logic                        dat_rd_dvld
);

    t_ll_rd_walk_state           state;
    t_ll_rd_op                   op_q;
    t_ll_rd_op                   cmd_op_t;
    logic [PTR_W-1:0]            cur_ptr;
    logic [CNT_W-1:0]            hops_q;
    logic [CNT_W:0]              hop_cnt;
    logic [CNT_W:0]              hop_nxt;
    logic [CNT_W:0]              hops_ext;
    logic [DATA_W-1:0]           data_q;
    logic [PTR_W-1:0]            link_q;
    logic                        got_dat;
    logic                        got_lnk;
    logic                        err_q;
    logic                        accept;
    logic                        hist_en;
    logic [HIST_DEPTH*PTR_W-1:0] hist_flat;

    // Hop counter is one bit wider than hops so hops='1 terminates without wrapping.
    always_comb begin
        cmd_op_t = t_ll_rd_op'(cmd_op);
        hop_nxt  = hop_cnt + {{CNT_W{1'b0}}, 1'b1};
        hops_ext = {1'b0, hops_q};
        accept   = (state == StIdle) && cmd_vld && cmd_rdy;
        hist_en  = (state == StWait) && nxt_rd_dvld;
    end

    ll_ptr_hist_shreg #(
        .PTR_W      (PTR_W),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept),
        .en      (hist_en),
        .din     (cur_ptr),
        .hist    (hist_flat)
    );

    // Walk FSM with registered strobes, handshakes and result capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= StIdle;
            op_q        <= OpSingle;
            cur_ptr     <= '0;
            hops_q      <= '0;
            hop_cnt     <= '0;
            data_q      <= '0;
            link_q      <= '0;
            got_dat     <= 1'b0;
            got_lnk     <= 1'b0;
            err_q       <= 1'b0;
            cmd_rdy     <= 1'b1;
            rsp_vld     <= 1'b0;
            nxt_rd_vld  <= 1'b0;
            nxt_rd_addr <= '0;
            dat_rd_vld  <= 1'b0;
            dat_rd_addr <= '0;
        end else begin
            nxt_rd_vld <= 1'b0;
            dat_rd_vld <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        cmd_rdy <= 1'b0;
                        op_q    <= cmd_op_t;
                        cur_ptr <= cmd_ptr;
                        hops_q  <= cmd_hops;
                        hop_cnt <= '0;
                        data_q  <= '0;
                        link_q  <= '0;
                        got_dat <= 1'b0;
                        got_lnk <= 1'b0;
                        err_q   <= 1'b0;
                        if (cmd_op_t == OpSingle || cmd_hops != '0) begin
                            state       <= StIssue;
                            nxt_rd_vld  <= 1'b1;
                            nxt_rd_addr <= cmd_ptr;
                        end else if (cmd_op_t == OpTravData) begin
                            state       <= StFetch;
                            nxt_rd_vld  <= 1'b1;
                            nxt_rd_addr <= cmd_ptr;
                            dat_rd_vld  <= 1'b1;
                            dat_rd_addr <= cmd_ptr;
                        end else begin
                            state   <= StResp;
                            rsp_vld <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    state <= StWait;
                end
                StWait: begin
                    if (nxt_rd_dvld) begin
                        hop_cnt <= hop_nxt;
                        if (op_q == OpSingle) begin
                            cur_ptr <= nxt_rd_data;
                            state   <= StResp;
                            rsp_vld <= 1'b1;
                        end else if (nxt_rd_data == NULL_PTR && hop_nxt < hops_ext) begin
                            // Early end of list: report the last real node.
                            err_q   <= 1'b1;
                            state   <= StResp;
                            rsp_vld <= 1'b1;
                        end else begin
                            cur_ptr <= nxt_rd_data;
                            if (hop_nxt == hops_ext) begin
                                if (op_q == OpTravData) begin
                                    state       <= StFetch;
                                    nxt_rd_vld  <= 1'b1;
                                    nxt_rd_addr <= nxt_rd_data;
                                    dat_rd_vld  <= 1'b1;
                                    dat_rd_addr <= nxt_rd_data;
                                end else begin
                                    state   <= StResp;
                                    rsp_vld <= 1'b1;
                                end
                            end else begin
                                state       <= StIssue;
                                nxt_rd_vld  <= 1'b1;
                                nxt_rd_addr <= nxt_rd_data;
                            end
                        end
                    end
                end
                StFetch: begin
                    state <= StFwait;
                end
                StFwait: begin
                    if (dat_rd_dvld) begin
                        data_q  <= dat_rd_data;
                        got_dat <= 1'b1;
                    end
                    if (nxt_rd_dvld) begin
                        link_q  <= nxt_rd_data;
                        got_lnk <= 1'b1;
                    end
                    if ((got_dat || dat_rd_dvld) && (got_lnk || nxt_rd_dvld)) begin
                        state   <= StResp;
                        rsp_vld <= 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        cmd_rdy <= 1'b1;
                        state   <= StIdle;
                    end
                end
                default: begin
                    state   <= StIdle;
                    cmd_rdy <= 1'b1;
                    rsp_vld <= 1'b0;
                end
            endcase
        end
    end

    // Response fields are held registers, masked to zero when unused by the op.
    always_comb begin
        rsp_ptr  = rsp_vld ? cur_ptr : '0;
        rsp_err  = rsp_vld && err_q;
        rsp_data = (rsp_vld && op_q == OpTravData) ? data_q : '0;
        rsp_link = (rsp_vld && op_q == OpTravData) ? link_q : '0;
        rsp_hist = (rsp_vld && op_q == OpTravHist) ? hist_flat : '0;
    end

endmodule

// File: tb/tb_ll_rd_walker_v3.sv
// Directed bench for ll_rd_walker_v3 with latency-programmable memory models.
module tb_ll_rd_walker_v3;
    import ll_rd_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_vld = 1'b0;
    logic        cmd_rdy;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_ptr = 8'd0;
    logic [7:0]  cmd_hops = 8'd0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [7:0]  rsp_ptr;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_link;
    logic [23:0] rsp_hist;
    logic        rsp_err;
    logic        nxt_rd_vld;
    logic [7:0]  nxt_rd_addr;
    logic [7:0]  nxt_rd_data = 8'd0;
    logic        nxt_rd_dvld;
    logic        dat_rd_vld;
    logic [7:0]  dat_rd_addr;
    logic [31:0] dat_rd_data = 32'd0;
    logic        dat_rd_dvld = 1'b0;

    logic        mdl_nxt_dvld = 1'b0;
    logic        stray_dvld = 1'b0;
    logic [7:0]  nxt_mem [256];
    int          nxt_lat = 1;
    int          dat_lat = 1;
    int          nxt_pend = 0;
    int          dat_pend = 0;
    logic [7:0]  nxt_pa = 8'd0;
    logic [7:0]  dat_pa = 8'd0;
    int          nxt_strobes = 0;
    int          dat_strobes = 0;
    int          checks = 0;
    int          errors = 0;
    int          n0;
    int          d0;

    assign nxt_rd_dvld = mdl_nxt_dvld | stray_dvld;

    always #5 clk = ~clk;

    ll_rd_walker_v3 #(
        .PTR_W      (8),
        .DATA_W     (32),
        .CNT_W      (8),
        .HIST_DEPTH (3),
        .NULL_PTR   (8'hFF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_vld     (cmd_vld),
        .cmd_rdy     (cmd_rdy),
        .cmd_op      (cmd_op),
        .cmd_ptr     (cmd_ptr),
        .cmd_hops    (cmd_hops),
        .rsp_vld     (rsp_vld),
        .rsp_rdy     (rsp_rdy),
        .rsp_ptr     (rsp_ptr),
        .rsp_data    (rsp_data),
        .rsp_link    (rsp_link),
        .rsp_hist    (rsp_hist),
        .rsp_err     (rsp_err),
        .nxt_rd_vld  (nxt_rd_vld),
        .nxt_rd_addr (nxt_rd_addr),
        .nxt_rd_data (nxt_rd_data),
        .nxt_rd_dvld (nxt_rd_dvld),
        .dat_rd_vld  (dat_rd_vld),
        .dat_rd_addr (dat_rd_addr),
        .dat_rd_data (dat_rd_data),
        .dat_rd_dvld (dat_rd_dvld)
    );

    // nxtptrMem model: answers each strobe after nxt_lat cycles.
    always @(posedge clk) begin
        mdl_nxt_dvld <= 1'b0;
        if (nxt_rd_vld) begin
            nxt_strobes <= nxt_strobes + 1;
            if (nxt_lat <= 1) begin
                mdl_nxt_dvld <= 1'b1;
                nxt_rd_data  <= nxt_mem[nxt_rd_addr];
            end else begin
                nxt_pend <= nxt_lat - 1;
                nxt_pa   <= nxt_rd_addr;
            end
        end else if (nxt_pend > 0) begin
            nxt_pend <= nxt_pend - 1;
            if (nxt_pend == 1) begin
                mdl_nxt_dvld <= 1'b1;
                nxt_rd_data  <= nxt_mem[nxt_pa];
            end
        end
    end

    // dataMem model: data word is 32'hCAFE_0000 | address.
    always @(posedge clk) begin
        dat_rd_dvld <= 1'b0;
        if (dat_rd_vld) begin
            dat_strobes <= dat_strobes + 1;
            if (dat_lat <= 1) begin
                dat_rd_dvld <= 1'b1;
                dat_rd_data <= {24'hCAFE00, dat_rd_addr};
            end else begin
                dat_pend <= dat_lat - 1;
                dat_pa   <= dat_rd_addr;
            end
        end else if (dat_pend > 0) begin
            dat_pend <= dat_pend - 1;
            if (dat_pend == 1) begin
                dat_rd_dvld <= 1'b1;
                dat_rd_data <= {24'hCAFE00, dat_pa};
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input t_ll_rd_op op, input logic [7:0] ptr, input logic [7:0] hops);
        @(negedge clk);
        chk("cmd_rdy_before_cmd", cmd_rdy, 1'b1);
        n0 = nxt_strobes;
        d0 = dat_strobes;
        cmd_vld  = 1'b1;
        cmd_op   = op;
        cmd_ptr  = ptr;
        cmd_hops = hops;
        @(posedge clk);
        #1 cmd_vld = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_vld !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_vld_within_budget", rsp_vld, 1'b1);
    endtask

    task automatic take_rsp();
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1 rsp_rdy = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) nxt_mem[i] = 8'hFF;
        nxt_mem[5] = 8'd9;
        nxt_mem[9] = 8'd2;
        nxt_mem[2] = 8'd7;
        nxt_mem[7] = 8'hFF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_rdy", cmd_rdy, 1'b1);
        chk("reset_rsp_vld", rsp_vld, 1'b0);
        chk("reset_nxt_rd_vld", nxt_rd_vld, 1'b0);
        chk("reset_dat_rd_vld", dat_rd_vld, 1'b0);
        chk("reset_rsp_ptr", rsp_ptr, 8'd0);
        chk("reset_rsp_hist", rsp_hist, 24'd0);

        // TRAVERSE 5, 3 hops: 5->9->2->7
        send(OpTraverse, 8'd5, 8'd3);
        wait_rsp();
        chk("trav_ptr", rsp_ptr, 8'd7);
        chk("trav_err", rsp_err, 1'b0);
        chk("trav_nxt_strobes", nxt_strobes - n0, 3);
        chk("trav_hist_zero", rsp_hist, 24'd0);
        chk("trav_data_zero", rsp_data, 32'd0);
        take_rsp();

        // TRAV_HIST 5, 3 hops
        send(OpTravHist, 8'd5, 8'd3);
        wait_rsp();
        chk("hist3_ptr", rsp_ptr, 8'd7);
        chk("hist3_hist", rsp_hist, 24'h05_09_02);
        take_rsp();

        // TRAV_HIST 5, 1 hop: zero-filled window
        send(OpTravHist, 8'd5, 8'd1);
        wait_rsp();
        chk("hist1_ptr", rsp_ptr, 8'd9);
        chk("hist1_hist", rsp_hist, 24'h00_00_05);
        take_rsp();

        // TRAV_DATA 5, 2 hops, slow dataMem
        dat_lat = 4;
        send(OpTravData, 8'd5, 8'd2);
        wait_rsp();
        chk("tdata_ptr", rsp_ptr, 8'd2);
        chk("tdata_data", rsp_data, 32'hCAFE_0002);
        chk("tdata_link", rsp_link, 8'd7);
        chk("tdata_nxt_strobes", nxt_strobes - n0, 3);
        chk("tdata_dat_strobes", dat_strobes - d0, 1);
        take_rsp();
        dat_lat = 1;

        // TRAV_DATA 9, 0 hops, slow nxtptrMem (link arrives after data)
        nxt_lat = 3;
        send(OpTravData, 8'd9, 8'd0);
        wait_rsp();
        chk("tdata0_ptr", rsp_ptr, 8'd9);
        chk("tdata0_data", rsp_data, 32'hCAFE_0009);
        chk("tdata0_link", rsp_link, 8'd2);
        chk("tdata0_nxt_strobes", nxt_strobes - n0, 1);
        take_rsp();
        nxt_lat = 1;

        // TRAVERSE 2, 5 hops: NULL after 2 hops
        send(OpTraverse, 8'd2, 8'd5);
        wait_rsp();
        chk("err_flag", rsp_err, 1'b1);
        chk("err_ptr", rsp_ptr, 8'd7);
        chk("err_nxt_strobes", nxt_strobes - n0, 2);
        take_rsp();

        // TRAVERSE 2, 0 hops: no memory access
        send(OpTraverse, 8'd2, 8'd0);
        wait_rsp();
        chk("hop0_ptr", rsp_ptr, 8'd2);
        chk("hop0_err", rsp_err, 1'b0);
        chk("hop0_nxt_strobes", nxt_strobes - n0, 0);
        chk("hop0_dat_strobes", dat_strobes - d0, 0);
        take_rsp();

        // SINGLE 5
        send(OpSingle, 8'd5, 8'd0);
        wait_rsp();
        chk("single_ptr", rsp_ptr, 8'd9);
        chk("single_hist", rsp_hist, 24'd0);
        take_rsp();

        // Backpressure: hold rsp_rdy low for 10 cycles
        send(OpTraverse, 8'd5, 8'd2);
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            chk("hold_rsp_vld", rsp_vld, 1'b1);
            chk("hold_rsp_ptr", rsp_ptr, 8'd2);
            chk("hold_cmd_rdy", cmd_rdy, 1'b0);
            @(negedge clk);
        end
        // Next SINGLE presented while the response transfers
        rsp_rdy  = 1'b1;
        cmd_vld  = 1'b1;
        cmd_op   = OpSingle;
        cmd_ptr  = 8'd9;
        cmd_hops = 8'd0;
        @(posedge clk);
        #1;
        rsp_rdy = 1'b0;
        chk("b2b_cmd_rdy_after_xfer", cmd_rdy, 1'b1);
        chk("b2b_rsp_vld_dropped", rsp_vld, 1'b0);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        chk("b2b_accepted", cmd_rdy, 1'b0);
        chk("b2b_strobe", nxt_rd_vld, 1'b1);
        chk("b2b_addr", nxt_rd_addr, 8'd9);
        wait_rsp();
        chk("b2b_ptr", rsp_ptr, 8'd2);
        take_rsp();

        // Reset in WAIT, then stray dvld while idle
        nxt_lat = 6;
        send(OpTraverse, 8'd5, 8'd3);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        stray_dvld = 1'b1;
        @(negedge clk);
        stray_dvld = 1'b0;
        chk("rst_mid_rsp_vld", rsp_vld, 1'b0);
        chk("rst_mid_cmd_rdy", cmd_rdy, 1'b1);
        repeat (10) @(negedge clk);
        chk("rst_mid_no_rsp", rsp_vld, 1'b0);
        chk("rst_mid_no_strobe", nxt_rd_vld, 1'b0);
        nxt_lat = 1;
        send(OpTraverse, 8'd5, 8'd3);
        wait_rsp();
        chk("post_rst_ptr", rsp_ptr, 8'd7);
        chk("post_rst_err", rsp_err, 1'b0);
        take_rsp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
